// File: rtl/cp0_exc_if.sv
// M-stage pipeline bundle between the core and the CP0 exception unit:
// exception flags and mtc0 commit in, flush/redirect out, plus the
// decode-stage mfc0 read port.
interface cp0_exc_if;
   logic        validM;
   logic        stallM;
   logic [31:0] pcM;
   logic        bdM;
   logic [31:0] dataaddrM;
   logic        adelM;
   logic        adesM;
   logic        syscallM;
   logic        breakM;
   logic        eretM;
   logic        invalidM;
   logic        overflowM;
   logic        cp0writeM;
   logic [4:0]  waddrM;
   logic [31:0] wdataM;
   logic [4:0]  raddrD;
   logic [31:0] rdataD;
   logic        flush;
   logic [31:0] newpc;

   modport master (
      output validM, stallM, pcM, bdM, dataaddrM,
      output adelM, adesM, syscallM, breakM, eretM, invalidM, overflowM,
      output cp0writeM, waddrM, wdataM, raddrD,
      input  rdataD, flush, newpc
   );

   modport slave (
      input  validM, stallM, pcM, bdM, dataaddrM,
      input  adelM, adesM, syscallM, breakM, eretM, invalidM, overflowM,
      input  cp0writeM, waddrM, wdataM, raddrD,
      output rdataD, flush, newpc
   );
endinterface

// File: rtl/cp0_exc.sv
// CP0 register file and M-stage exception resolver. Decides whether the
// instruction in M traps or erets, drives flush/newpc combinationally, and
// updates BadVAddr, Count, Compare, Status, Cause and EPC on the closing edge.
module cp0_exc #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        reset,
   cp0_exc_if.slave    m,
   input  logic [5:0]  ext_int,
   output logic [31:0] epc_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic        timer_int
);
   localparam logic [4:0] R_BADVADDR = 5'd8;
   localparam logic [4:0] R_COUNT    = 5'd9;
   localparam logic [4:0] R_COMPARE  = 5'd11;
   localparam logic [4:0] R_STATUS   = 5'd12;
   localparam logic [4:0] R_CAUSE    = 5'd13;
   localparam logic [4:0] R_EPC      = 5'd14;

   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] epc_q, epc_d;
   logic        tick_q, tick_d;
   logic        timer_q, timer_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exccode_q, exccode_d;

   logic [31:0] status_w, cause_w;
   logic        commit, int_pend;
   logic        take, is_eret, bad_ld, wr;
   logic [4:0]  exc;
   logic [31:0] bad_val;

   assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_w  = {bd_q, 15'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
   assign commit   = m.validM & ~m.stallM;
   assign int_pend = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

   // Prioritised trap resolution for the instruction in M.
   always_comb begin
      take    = 1'b0;
      is_eret = 1'b0;
      exc     = 5'h00;
      bad_ld  = 1'b0;
      bad_val = 32'd0;
      if (commit) begin
         if (int_pend) begin
            take = 1'b1; exc = 5'h00;
         end else if (m.adelM && (m.pcM[1:0] != 2'b00)) begin
            take = 1'b1; exc = 5'h04; bad_ld = 1'b1; bad_val = m.pcM;
         end else if (m.invalidM) begin
            take = 1'b1; exc = 5'h0A;
         end else if (m.syscallM) begin
            take = 1'b1; exc = 5'h08;
         end else if (m.breakM) begin
            take = 1'b1; exc = 5'h09;
         end else if (m.overflowM) begin
            take = 1'b1; exc = 5'h0C;
         end else if (m.adelM) begin
            take = 1'b1; exc = 5'h04; bad_ld = 1'b1; bad_val = m.dataaddrM;
         end else if (m.adesM) begin
            take = 1'b1; exc = 5'h05; bad_ld = 1'b1; bad_val = m.dataaddrM;
         end else if (m.eretM) begin
            is_eret = 1'b1;
         end
      end
   end

   assign wr      = commit & m.cp0writeM & ~take & ~is_eret;
   assign m.flush = ~reset & (take | is_eret);
   assign m.newpc = is_eret ? epc_q : EXC_VECTOR;

   // Next-state for all CP0 registers; trap updates override mtc0 fields.
   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = tick_q ? count_q + 32'd1 : count_q;
      tick_d     = ~tick_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_hw_d    = {ext_int[5] | timer_q, ext_int[4:0]};
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;

      if (wr) begin
         case (m.waddrM)
            R_COUNT: begin
               count_d = m.wdataM;
               tick_d  = 1'b0;
            end
            R_COMPARE: compare_d = m.wdataM;
            R_STATUS: begin
               im_d  = m.wdataM[15:8];
               exl_d = m.wdataM[1];
               ie_d  = m.wdataM[0];
            end
            R_CAUSE:  ip_sw_d = m.wdataM[9:8];
            R_EPC:    epc_d   = m.wdataM;
            default: ;
         endcase
      end

      // Compare against the value Count is about to hold so the latch
      // rises on the same edge Count reaches Compare.
      timer_d = timer_q | ((count_d == compare_q) && (compare_q != 32'd0));
      if (wr && (m.waddrM == R_COMPARE)) timer_d = 1'b0;

      if (take) begin
         if (!exl_q) begin
            epc_d = m.bdM ? m.pcM - 32'd4 : m.pcM;
            bd_d  = m.bdM;
         end
         exl_d     = 1'b1;
         exccode_d = exc;
         if (bad_ld) badvaddr_d = bad_val;
      end
      if (is_eret) exl_d = 1'b0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_q <= 32'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         epc_q      <= 32'd0;
         tick_q     <= 1'b0;
         timer_q    <= 1'b0;
         im_q       <= 8'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_hw_q    <= 6'd0;
         ip_sw_q    <= 2'd0;
         exccode_q  <= 5'd0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         tick_q     <= tick_d;
         timer_q    <= timer_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
      end
   end

   // mfc0 read mux; unimplemented numbers read as zero.
   always_comb begin
      case (m.raddrD)
         R_BADVADDR: m.rdataD = badvaddr_q;
         R_COUNT:    m.rdataD = count_q;
         R_COMPARE:  m.rdataD = compare_q;
         R_STATUS:   m.rdataD = status_w;
         R_CAUSE:    m.rdataD = cause_w;
         R_EPC:      m.rdataD = epc_q;
         default:    m.rdataD = 32'd0;
      endcase
   end

   assign epc_o     = epc_q;
   assign status_o  = status_w;
   assign cause_o   = cause_w;
   assign timer_int = timer_q;
endmodule

// File: tb/tb_cp0_exc.sv
// Directed bench for cp0_exc: a vector table walks the trap/eret/mtc0
// behaviour from reset, followed by interrupt, timer and reset sequences.
module tb_cp0_exc;
   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] ext_int;
   logic [31:0] epc_o, status_o, cause_o;
   logic       timer_int;
   int checks = 0;
   int errors = 0;

   cp0_exc_if bus ();

   cp0_exc #(.EXC_VECTOR(32'hBFC0_0380)) dut (
      .clk(clk), .reset(reset), .m(bus), .ext_int(ext_int),
      .epc_o(epc_o), .status_o(status_o), .cause_o(cause_o),
      .timer_int(timer_int)
   );

   always #5 clk = ~clk;

   // flag vector order: {adel, ades, syscall, break, eret, invalid, overflow}
   localparam logic [6:0] F_NONE = 7'b0000000;
   localparam logic [6:0] F_ADEL = 7'b1000000;
   localparam logic [6:0] F_ADES = 7'b0100000;
   localparam logic [6:0] F_SYS  = 7'b0010000;
   localparam logic [6:0] F_BRK  = 7'b0001000;
   localparam logic [6:0] F_ERET = 7'b0000100;
   localparam logic [6:0] F_INV  = 7'b0000010;
   localparam logic [6:0] F_OVF  = 7'b0000001;
   localparam logic [31:0] VEC   = 32'hBFC0_0380;

   typedef struct {
      logic        stall;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] daddr;
      logic [6:0]  fl;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ef;
      logic [31:0] enp;
      logic [31:0] epc;
      logic [31:0] st;
      logic [31:0] ca;
      logic [31:0] bad;
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.validM = 1'b0; bus.stallM = 1'b0; bus.pcM = 32'd0; bus.bdM = 1'b0;
      bus.dataaddrM = 32'd0;
      {bus.adelM, bus.adesM, bus.syscallM, bus.breakM, bus.eretM, bus.invalidM, bus.overflowM} = 7'd0;
      bus.cp0writeM = 1'b0; bus.waddrM = 5'd0; bus.wdataM = 32'd0;
   endtask

   // Present one instruction in M at the falling edge.
   task automatic drive(input logic stall, input logic [31:0] pc, input logic bd,
                        input logic [31:0] daddr, input logic [6:0] fl,
                        input logic wr, input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clk);
      bus.validM = 1'b1; bus.stallM = stall; bus.pcM = pc; bus.bdM = bd;
      bus.dataaddrM = daddr;
      {bus.adelM, bus.adesM, bus.syscallM, bus.breakM, bus.eretM, bus.invalidM, bus.overflowM} = fl;
      bus.cp0writeM = wr; bus.waddrM = wa; bus.wdataM = wd;
      #1;
   endtask

   task automatic retire();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      bus.raddrD = a;
      #1;
      v = bus.rdataD;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      //          stall pc            bd daddr          fl            wr wa     wd             ef enp            epc            status         cause          bad
      vt[0]  = '{1'b0, 32'h8000_0010, 1'b0, 32'h0, F_SYS,        1'b0, 5'd0,  32'h0,         1'b1, VEC,          32'h8000_0010, 32'h0040_0002, 32'h0000_0020, 32'h0};
      vt[1]  = '{1'b0, 32'h8000_0014, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0010, 32'h8000_0010, 32'h0040_0000, 32'h0000_0020, 32'h0};
      vt[2]  = '{1'b0, 32'h8000_0010, 1'b1, 32'h0, F_SYS,        1'b0, 5'd0,  32'h0,         1'b1, VEC,          32'h8000_000C, 32'h0040_0002, 32'h8000_0020, 32'h0};
      vt[3]  = '{1'b0, 32'h8000_0018, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_000C, 32'h8000_000C, 32'h0040_0000, 32'h8000_0020, 32'h0};
      vt[4]  = '{1'b0, 32'h8000_0002, 1'b0, 32'h0, F_ADEL,       1'b0, 5'd0,  32'h0,         1'b1, VEC,          32'h8000_0002, 32'h0040_0002, 32'h0000_0010, 32'h8000_0002};
      vt[5]  = '{1'b0, 32'h8000_001C, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0002, 32'h8000_0002, 32'h0040_0000, 32'h0000_0010, 32'h8000_0002};
      vt[6]  = '{1'b0, 32'h8000_0020, 1'b0, 32'h1000_0003, F_ADES, 1'b0, 5'd0, 32'h0,        1'b1, VEC,          32'h8000_0020, 32'h0040_0002, 32'h0000_0014, 32'h1000_0003};
      vt[7]  = '{1'b0, 32'h8000_0030, 1'b1, 32'h0, F_INV|F_BRK,  1'b0, 5'd0,  32'h0,         1'b1, VEC,          32'h8000_0020, 32'h0040_0002, 32'h0000_0028, 32'h1000_0003};
      vt[8]  = '{1'b0, 32'h8000_0034, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0020, 32'h8000_0020, 32'h0040_0000, 32'h0000_0028, 32'h1000_0003};
      vt[9]  = '{1'b0, 32'h8000_0040, 1'b0, 32'h0, F_OVF,        1'b1, 5'd14, 32'h1234_5678, 1'b1, VEC,          32'h8000_0040, 32'h0040_0002, 32'h0000_0030, 32'h1000_0003};
      vt[10] = '{1'b0, 32'h8000_0044, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0040, 32'h8000_0040, 32'h0040_0000, 32'h0000_0030, 32'h1000_0003};
      vt[11] = '{1'b0, 32'h8000_0048, 1'b0, 32'h0, F_NONE,       1'b1, 5'd14, 32'h1234_5678, 1'b0, VEC,          32'h1234_5678, 32'h0040_0000, 32'h0000_0030, 32'h1000_0003};
      vt[12] = '{1'b1, 32'h8000_0050, 1'b0, 32'h0, F_SYS,        1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, VEC,          32'h1234_5678, 32'h0040_0000, 32'h0000_0030, 32'h1000_0003};
      vt[13] = '{1'b0, 32'h8000_0060, 1'b0, 32'h2000_0001, F_ADEL, 1'b0, 5'd0, 32'h0,        1'b1, VEC,          32'h8000_0060, 32'h0040_0002, 32'h0000_0010, 32'h2000_0001};
      vt[14] = '{1'b0, 32'h8000_0064, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0060, 32'h8000_0060, 32'h0040_0000, 32'h0000_0010, 32'h2000_0001};
      vt[15] = '{1'b0, 32'h8000_0068, 1'b0, 32'h0, F_NONE,       1'b1, 5'd12, 32'h0000_FF01, 1'b0, VEC,          32'h8000_0060, 32'h0040_FF01, 32'h0000_0010, 32'h2000_0001};
      vt[16] = '{1'b0, 32'h8000_006C, 1'b0, 32'h0, F_NONE,       1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, VEC,          32'h8000_0060, 32'h0040_FF01, 32'h0000_0310, 32'h2000_0001};
      vt[17] = '{1'b0, 32'h8000_0070, 1'b0, 32'h0, F_NONE,       1'b0, 5'd0,  32'h0,         1'b1, VEC,          32'h8000_0070, 32'h0040_FF03, 32'h0000_0300, 32'h2000_0001};
      vt[18] = '{1'b0, 32'h8000_0074, 1'b0, 32'h0, F_NONE,       1'b1, 5'd13, 32'h0,         1'b0, VEC,          32'h8000_0070, 32'h0040_FF03, 32'h0000_0000, 32'h2000_0001};
      vt[19] = '{1'b0, 32'h8000_0078, 1'b0, 32'h0, F_ERET,       1'b0, 5'd0,  32'h0,         1'b1, 32'h8000_0070, 32'h8000_0070, 32'h0040_FF01, 32'h0000_0000, 32'h2000_0001};

      idle();
      ext_int = 6'd0;
      bus.raddrD = 5'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", status_o, 32'h0040_0000);
      chk("rst_cause", cause_o, 32'h0);
      chk("rst_epc", epc_o, 32'h0);
      chk("rst_timer", {31'd0, timer_int}, 32'd0);
      chk("rst_flush", {31'd0, bus.flush}, 32'd0);
      rd(5'd9, v);  chk("rst_count", v, 32'h0);
      rd(5'd8, v);  chk("rst_badvaddr", v, 32'h0);
      rd(5'd11, v); chk("rst_compare", v, 32'h0);
      rd(5'd12, v); chk("rst_rd_status", v, 32'h0040_0000);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].stall, vt[i].pc, vt[i].bd, vt[i].daddr, vt[i].fl, vt[i].wr, vt[i].wa, vt[i].wd);
         chk($sformatf("v%0d_flush", i), {31'd0, bus.flush}, {31'd0, vt[i].ef});
         if (vt[i].ef) chk($sformatf("v%0d_newpc", i), bus.newpc, vt[i].enp);
         retire();
         chk($sformatf("v%0d_epc", i), epc_o, vt[i].epc);
         chk($sformatf("v%0d_status", i), status_o, vt[i].st);
         chk($sformatf("v%0d_cause", i), cause_o, vt[i].ca);
         rd(5'd8, v);
         chk($sformatf("v%0d_badvaddr", i), v, vt[i].bad);
      end
      rd(5'd10, v); chk("rd_unimpl", v, 32'h0);
      rd(5'd14, v); chk("rd_epc", v, 32'h8000_0070);

      // Hardware interrupt on IP[10], then the same with EXL=1.
      ext_int = 6'b000001;
      repeat (2) @(posedge clk);
      drive(1'b0, 32'h8000_0080, 1'b0, 32'h0, F_NONE, 1'b0, 5'd0, 32'h0);
      chk("hwint_flush", {31'd0, bus.flush}, 32'd1);
      chk("hwint_newpc", bus.newpc, VEC);
      retire();
      chk("hwint_cause", cause_o, 32'h0000_0400);
      chk("hwint_status", status_o, 32'h0040_FF03);
      chk("hwint_epc", epc_o, 32'h8000_0080);
      drive(1'b0, 32'h8000_0090, 1'b0, 32'h0, F_NONE, 1'b0, 5'd0, 32'h0);
      chk("hwint_exl_flush", {31'd0, bus.flush}, 32'd0);
      retire();
      chk("hwint_exl_epc", epc_o, 32'h8000_0080);
      ext_int = 6'd0;
      drive(1'b0, 32'h8000_0094, 1'b0, 32'h0, F_ERET, 1'b0, 5'd0, 32'h0);
      chk("hwint_eret_newpc", bus.newpc, 32'h8000_0080);
      retire();
      chk("hwint_eret_status", status_o, 32'h0040_FF01);

      // Timer: mask interrupts, Compare=10, Count=0, wait for the latch.
      drive(1'b0, 32'h8000_00A0, 1'b0, 32'h0, F_NONE, 1'b1, 5'd12, 32'h0);
      retire();
      chk("tmr_status", status_o, 32'h0040_0000);
      drive(1'b0, 32'h8000_00A4, 1'b0, 32'h0, F_NONE, 1'b1, 5'd11, 32'd10);
      retire();
      drive(1'b0, 32'h8000_00A8, 1'b0, 32'h0, F_NONE, 1'b1, 5'd9, 32'd0);
      @(posedge clk);
      #1;
      idle();
      rd(5'd9, v); chk("tmr_count0", v, 32'd0);
      repeat (19) @(posedge clk);
      #1;
      chk("tmr_before", {31'd0, timer_int}, 32'd0);
      @(posedge clk);
      #1;
      chk("tmr_rise", {31'd0, timer_int}, 32'd1);
      rd(5'd9, v); chk("tmr_count10", v, 32'd10);
      @(posedge clk);
      #1;
      chk("tmr_cause15", {31'd0, cause_o[15]}, 32'd1);
      drive(1'b0, 32'h8000_00AC, 1'b0, 32'h0, F_NONE, 1'b1, 5'd11, 32'd10);
      chk("tmr_hold", {31'd0, timer_int}, 32'd1);
      retire();
      chk("tmr_clear", {31'd0, timer_int}, 32'd0);
      rd(5'd11, v); chk("tmr_compare", v, 32'd10);

      // Reset asserted on the cycle a syscall is in M.
      drive(1'b0, 32'h8000_00B0, 1'b1, 32'h0, F_SYS, 1'b0, 5'd0, 32'h0);
      reset = 1'b1;
      #1;
      chk("rst_trap_flush", {31'd0, bus.flush}, 32'd0);
      retire();
      reset = 1'b0;
      chk("rst_trap_status", status_o, 32'h0040_0000);
      chk("rst_trap_epc", epc_o, 32'h0);
      chk("rst_trap_cause", cause_o, 32'h0);
      rd(5'd11, v); chk("rst_trap_compare", v, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
